// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control unit of the multicycle RV32I core. Steps the shared datapath
//   through fetch/decode/execute/memory/writeback and decodes every mux select
//   and write strobe combinationally from the registered state and IR fields.
//
//   Optional build macro: MEM_STALL_EN
//     defined   - FETCH, MEMREAD and MEMWRITE wait for mem_ready
//     undefined - mem_ready is ignored, every memory state lasts one cycle
//
//   Ports
//     clk, rst            system clock (rising edge), synchronous active-high reset
//     op, funct3, funct7b5 instruction register fields
//     Zero                ALU zero flag (branch decision)
//     mem_ready           memory access complete (stall build only)
//     PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath strobes/selects
//     ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath mux/ALU controls
//     instr_done          one-cycle pulse in the last state of an instruction
//     illegal_op          one-cycle pulse in DECODE for an unsupported opcode
//     state_o             current state code (debug)
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC + 4
//   DECODE   | read registers, ALUOut <= OldPC + imm (branch/jump target)
//   MEMADR   | ALUOut <= rs1 + imm (load/store address)
//   MEMREAD  | read data memory at ALUOut
//   MEMWB    | rd <= loaded data
//   MEMWRITE | write rs2 to memory at ALUOut
//   EXECUTER | ALUOut <= rs1 op rs2
//   EXECUTEI | ALUOut <= rs1 op imm
//   ALUWB    | rd <= ALUOut
//   BEQ      | compare rs1/rs2, PC <= ALUOut when equal
//   JAL      | PC <= ALUOut, ALUOut <= OldPC + 4 (link value)

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  stateT      state;
  logic       memGo;
  logic       legalOp;
  logic       pcUpdate;
  logic       branch;
  logic [1:0] aluOp;

  // memGo: the memory side has finished the access of the current state.
`ifdef MEM_STALL_EN
  assign memGo = mem_ready;
`else
  logic unusedMemReady;
  assign unusedMemReady = mem_ready;
  assign memGo = 1'b1;
`endif

  always_comb begin
    legalOp = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: legalOp = 1'b1;
      default: legalOp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (memGo) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXECUTER;
            OP_ITYPE:          state <= EXECUTEI;
            OP_BRANCH:         state <= BEQ;
            OP_JAL:            state <= JAL;
            default:           state <= FETCH;
          endcase
        end
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (memGo) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (memGo) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    aluOp      = 2'b00;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = memGo;
        pcUpdate  = memGo;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        illegal_op = ~legalOp;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = memGo;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        aluOp      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      default: ;
    endcase

    PCWrite = pcUpdate | (branch & Zero);

    // Reset abandons the instruction in flight: no state-changing strobe may
    // leak out while rst is high, whatever the state register still holds.
    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign state_o = state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle RV32I core. It sequences the shared datapath (PC/ALU/register file/unified memory/immediate sign-extender) through fetch, decode, execute, memory and writeback states. It produces every mux select, write strobe, the immediate-format select `ImmSrc` and `ALUControl`. One instance sits beside the datapath; all outputs are decoded combinationally from the registered state and the instruction fields.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: `Instr[6:0]` from the instruction register.
- `funct3` in 3: `Instr[14:12]`.
- `funct7b5` in 1: `Instr[30]`.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access complete; used only with `MEM_STALL_EN`.
- `PCWrite`, `AdrSrc`, `MemWrite`, `IRWrite`, `RegWrite` out 1 each: PC enable, address mux (0 = PC, 1 = ALUOut), store strobe, IR/OldPC enable, and register file write.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode.
- `state_o` out 4: current state encoding, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 are unreachable; if entered, the next state is FETCH.
- Unlisted outputs in each state are 0, and 00/000 for multi-bit outputs.
- PCWrite = PCUpdate | (Branch & Zero). PCUpdate and Branch are internal signals.
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state DECODE.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH, with illegal_op=1.
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op[5]=0, else MEMWRITE.
- **MEMREAD:** ResultSrc=00, AdrSrc=1. Next state MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1, instr_done=1. Next state FETCH.
- **MEMWRITE:** ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1. Next state FETCH.
- **EXECUTER:** ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- **EXECUTEI:** ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1, instr_done=1. Next state FETCH.
- **BEQ:** ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next state FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
- **ImmSrc:** decoded from `op` in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - all other opcodes → 00.
- **ALU decoder:**
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by funct3:
    - 000 → sub if (op[5] & funct7b5), else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other funct3 → add.

## Timing
- Registered state; all outputs are combinational from state and the IR fields, with no output registers.
- **Reset:** while `rst`=1, PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal_op are forced to 0. The state becomes FETCH at the first rising edge with `rst`=1.
- **Reset during an instruction:** an asserted reset abandons the instruction. No partial register-file or memory write occurs after the reset edge.
- **Cycles per instruction (no stall):** lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, illegal opcode 2.
- **Branch:** taken when Zero=1 in the BEQ cycle; the PC loads ALUOut (the target computed in DECODE).
- instr_done is high for exactly one cycle per legal instruction.

## Configuration
- `MEM_STALL_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold until `mem_ready`=1.
  - In FETCH, IRWrite and PCUpdate assert only in the cycle where `mem_ready`=1.
  - MemWrite stays high throughout MEMWRITE; instr_done pulses only on the exit cycle.
  - Each wait cycle adds one cycle to the counts above.
- `MEM_STALL_EN` undefined: `mem_ready` is ignored; each memory state lasts one cycle.

## Test plan
- Reset: hold `rst` 2 cycles mid-EXECUTER → state_o=0, strobes 0 during reset, FETCH on first cycle after release.
- lw (op=0000011): state_o sequence 0,1,2,3,4; RegWrite=1 with ResultSrc=01 only in state 4; ImmSrc=00.
- sw (op=0100011): sequence 0,1,2,5; MemWrite=1 in state 5 only; ImmSrc=01.
- beq: with Zero=1 → PCWrite=1 in state 9; with Zero=0 → PCWrite=0 in state 9; ALUControl=001 there.
- sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in state 6. Same fields with op=0010011 → 000. funct3=111 → 010.
- Illegal opcode 0000000 → illegal_op pulse in DECODE, back to FETCH. With `MEM_STALL_EN`, `mem_ready`=0 for 3 cycles in FETCH → IRWrite low 3 cycles, then high 1 cycle.
